serial_adder: RTL



---
 rtl/serial_adder_if.sv | 33 +++
 rtl/serial_adder.sv | 114 +++++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// ============================================================================
// Module      : serial_adder_if
// Description : Operand/result bundle for the bit-serial adder. The master
//               side supplies operands and start; the slave side returns
//               busy, done and the parallel result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, carry
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, carry
    );
endinterface

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder. Captures two WIDTH-bit operands and a
//               carry-in on start, adds one bit per clock LSB first through a
//               single full-add step, then presents {carry, sum} with a
//               one-cycle done strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    serial_adder_if.slave bus
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] acc_q;
    logic             cr_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    logic             w_sbit;
    logic             w_cout;
    logic [WIDTH-1:0] acc_d;

    // One-bit full-add step on the current LSBs and the running carry.
    always_comb begin
        w_sbit = sa_q[0] ^ sb_q[0] ^ cr_q;
        w_cout = (sa_q[0] & sb_q[0]) | (cr_q & (sa_q[0] ^ sb_q[0]));
    end

    // The accumulator shifts right with the new sum bit entering at the MSB;
    // a one-bit accumulator simply takes the sum bit.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign acc_d = w_sbit;
        end else begin : g_acc_wn
            assign acc_d = {w_sbit, acc_q[WIDTH-1:1]};
        end
    endgenerate

    // Control FSM and datapath; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            cr_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sa_q    <= bus.a;
                        sb_q    <= bus.b;
                        cr_q    <= bus.c_in;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    acc_q <= acc_d;
                    cr_q  <= w_cout;
                    cnt_q <= cnt_q + CW'(1);
                    // Final bit: publish the result in the same edge.
                    if (cnt_q == LAST) begin
                        sum_q   <= acc_d;
                        carry_q <= w_cout;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.carry = carry_q;

endmodule

`default_nettype wire
